ex_alu: RTL and testbench

- Execute-stage ALU, directly downstream of the execute operand-select stage.
- Consumes aluin1/aluin2, operation, opselect, shift_number, enable_arith and enable_shift; produces a registered 32-bit aluout plus carry, zero and overflow flags.
- Its output feeds memory access (address on MEM_READ) and writeback.
- A one-cycle out_valid strobe marks each new result.

---
 rtl/ex_alu.sv | 194 +++++++++++++++++++
 tb/tb_ex_alu.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_alu.sv
// Execute-stage ALU: registered arithmetic/logic/address/shift result with carry, zero, overflow flags.
// Optional macro EX_ALU_SERIAL_SHIFT_EN replaces the barrel shifter with a bit-serial shifter FSM.
module ex_alu #(
    parameter int         WIDTH       = 32,
    parameter logic [2:0] SHIFT_REG   = 3'b000,
    parameter logic [2:0] ARITH_LOGIC = 3'b001,
    parameter logic [2:0] MEM_READ    = 3'b101
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] aluin1,
    input  logic [WIDTH-1:0] aluin2,
    input  logic [2:0]       operation,
    input  logic [2:0]       opselect,
    input  logic [4:0]       shift_number,
    input  logic             enable_arith,
    input  logic             enable_shift,
    output logic [WIDTH-1:0] aluout,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic             out_valid,
    output logic             busy
);

    function automatic logic [WIDTH-1:0] shift_op(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] val,
                                                  input logic [4:0] amt);
        logic signed [WIDTH-1:0] val_s;
        val_s = val;
        case (op)
            3'b000, 3'b010: return val << amt;
            3'b001:         return val >> amt;
            3'b011:         return $unsigned(val_s >>> amt);
            default:        return val;
        endcase
    endfunction

    logic [WIDTH-1:0] aluout_q, aluout_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] arith_res;
    logic             arith_c, arith_v;
    logic [WIDTH-1:0] shift_res;
    logic             accept_arith, shift_done;

    logic [WIDTH:0] sum_w, diff_w;
    logic [16:0]    hsum_w;
    assign sum_w  = {1'b0, aluin1} + {1'b0, aluin2};
    assign diff_w = {1'b0, aluin1} - {1'b0, aluin2};
    assign hsum_w = {1'b0, aluin1[15:0]} + {1'b0, aluin2[15:0]};

    always_comb begin
        arith_res = '0;
        arith_c   = 1'b0;
        arith_v   = 1'b0;
        if (opselect == ARITH_LOGIC) begin
            case (operation)
                3'b000: begin
                    arith_res = sum_w[WIDTH-1:0];
                    arith_c   = sum_w[WIDTH];
                    arith_v   = (aluin1[WIDTH-1] == aluin2[WIDTH-1]) &&
                                (sum_w[WIDTH-1] != aluin1[WIDTH-1]);
                end
                3'b001: begin
                    arith_res = {{(WIDTH-16){hsum_w[15]}}, hsum_w[15:0]};
                    arith_c   = hsum_w[16];
                    arith_v   = (aluin1[15] == aluin2[15]) && (hsum_w[15] != aluin1[15]);
                end
                3'b010: begin
                    // Bit WIDTH of the zero-extended difference is the unsigned borrow.
                    arith_res = diff_w[WIDTH-1:0];
                    arith_c   = diff_w[WIDTH];
                    arith_v   = (aluin1[WIDTH-1] != aluin2[WIDTH-1]) &&
                                (diff_w[WIDTH-1] != aluin1[WIDTH-1]);
                end
                3'b011:  arith_res = ~aluin2;
                3'b100:  arith_res = aluin1 & aluin2;
                3'b101:  arith_res = aluin1 | aluin2;
                3'b110:  arith_res = aluin1 ^ aluin2;
                default: arith_res = {aluin2[15:0], {(WIDTH-16){1'b0}}};
            endcase
        end else if (opselect == MEM_READ) begin
            arith_res = sum_w[WIDTH-1:0];
        end
    end

`ifdef EX_ALU_SERIAL_SHIFT_EN
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_val_q, sh_val_d;
    logic [2:0]       sh_op_q, sh_op_d;
    logic [4:0]       sh_cnt_q, sh_cnt_d;

    always_comb begin
        state_d      = state_q;
        sh_val_d     = sh_val_q;
        sh_op_d      = sh_op_q;
        sh_cnt_d     = sh_cnt_q;
        accept_arith = 1'b0;
        shift_done   = 1'b0;
        shift_res    = sh_val_q;
        case (state_q)
            IDLE: begin
                if (enable_arith) begin
                    accept_arith = 1'b1;
                end else if (enable_shift) begin
                    if (shift_number == 5'd0) begin
                        shift_done = 1'b1;
                        shift_res  = aluin1;
                    end else begin
                        sh_val_d = aluin1;
                        sh_op_d  = operation;
                        sh_cnt_d = shift_number;
                        state_d  = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sh_val_d = shift_op(sh_op_q, sh_val_q, 5'd1);
                sh_cnt_d = sh_cnt_q - 5'd1;
                if (sh_cnt_q == 5'd1) state_d = DONE;
            end
            DONE: begin
                shift_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Shift working registers are qualified by state, so they need no reset.
    always_ff @(posedge clk) begin
        sh_val_q <= sh_val_d;
        sh_op_q  <= sh_op_d;
        sh_cnt_q <= sh_cnt_d;
    end

    assign busy = (state_q == SHIFT);
`else
    assign accept_arith = enable_arith;
    assign shift_done   = enable_shift & ~enable_arith;
    assign shift_res    = shift_op(operation, aluin1, shift_number);
    assign busy         = 1'b0;
`endif

    always_comb begin
        aluout_d   = aluout_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        if (accept_arith) begin
            aluout_d   = arith_res;
            carry_d    = arith_c;
            overflow_d = arith_v;
            valid_d    = 1'b1;
        end else if (shift_done) begin
            aluout_d = shift_res;
            valid_d  = 1'b1;
        end
        zero_d = valid_d ? (aluout_d == '0) : zero_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aluout_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            aluout_q   <= aluout_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            valid_q    <= valid_d;
        end
    end

    assign aluout    = aluout_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_ex_alu.sv
// Directed self-checking bench for ex_alu; serial-shifter checks are built when EX_ALU_SERIAL_SHIFT_EN is defined.
module tb_ex_alu;

    localparam logic [2:0] SHIFT_REG   = 3'b000;
    localparam logic [2:0] ARITH_LOGIC = 3'b001;
    localparam logic [2:0] MEM_READ    = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] aluin1, aluin2;
    logic [2:0]  operation, opselect;
    logic [4:0]  shift_number;
    logic        enable_arith, enable_shift;
    logic [31:0] aluout;
    logic        carry, zero, overflow, out_valid, busy;

    int n_assert = 0;
    int n_fail   = 0;

    ex_alu dut (
        .clk(clk), .rst(rst), .aluin1(aluin1), .aluin2(aluin2),
        .operation(operation), .opselect(opselect), .shift_number(shift_number),
        .enable_arith(enable_arith), .enable_shift(enable_shift),
        .aluout(aluout), .carry(carry), .zero(zero), .overflow(overflow),
        .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ea, input logic es, input logic [2:0] sel, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] n);
        enable_arith = ea;
        enable_shift = es;
        opselect     = sel;
        operation    = op;
        aluin1       = a;
        aluin2       = b;
        shift_number = n;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 3'b000, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic arith(input logic [2:0] sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(1'b1, 1'b0, sel, op, a, b, 5'd0);
        tick();
        idle();
    endtask

    // Issue a shift and return once its result is visible (bounded wait in the serial build).
    task automatic shift_req(input logic [2:0] op, input logic [31:0] a, input logic [4:0] n);
        drive(1'b0, 1'b1, SHIFT_REG, op, a, 32'h0, n);
        tick();
        idle();
`ifdef EX_ALU_SERIAL_SHIFT_EN
        for (int i = 0; i < 40 && out_valid !== 1'b1; i++) tick();
`endif
    endtask

    task automatic chk_res(input string tag, input logic [31:0] res, input logic c, input logic v);
        chk({tag, "_out"},   aluout,    res);
        chk({tag, "_carry"}, carry,     c);
        chk({tag, "_ovf"},   overflow,  v);
        chk({tag, "_zero"},  zero,      res == 32'h0);
        chk({tag, "_vld"},   out_valid, 1'b1);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        tick();
        chk("rst_out", aluout, 32'h0);
        chk("rst_vld", out_valid, 1'b0);
        chk("rst_zero", zero, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        chk("idle_out", aluout, 32'h0);
        chk("idle_vld", out_valid, 1'b0);
        chk("idle_flags", {carry, zero, overflow}, 3'b000);

        arith(ARITH_LOGIC, 3'b000, 32'hFFFF_FFFF, 32'h1);
        chk_res("add_wrap", 32'h0, 1'b1, 1'b0);
        arith(ARITH_LOGIC, 3'b000, 32'h7FFF_FFFF, 32'h1);
        chk_res("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
        arith(ARITH_LOGIC, 3'b001, 32'hABCD_7FFF, 32'h5555_0001);
        chk_res("hadd_ovf", 32'hFFFF_8000, 1'b0, 1'b1);
        arith(ARITH_LOGIC, 3'b001, 32'h1234_FFFF, 32'h0000_0001);
        chk_res("hadd_carry", 32'h0, 1'b1, 1'b0);
        arith(ARITH_LOGIC, 3'b010, 32'd5, 32'd7);
        chk_res("sub_borrow", 32'hFFFF_FFFE, 1'b1, 1'b0);
        arith(ARITH_LOGIC, 3'b010, 32'h8000_0000, 32'h1);
        chk_res("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1);
        arith(ARITH_LOGIC, 3'b111, 32'hFFFF_FFFF, 32'hAAAA_1234);
        chk_res("lhg", 32'h1234_0000, 1'b0, 1'b0);
        arith(ARITH_LOGIC, 3'b011, 32'h0, 32'h0F0F_0F0F);
        chk_res("not", 32'hF0F0_F0F0, 1'b0, 1'b0);
        arith(ARITH_LOGIC, 3'b100, 32'hF0F0_FF00, 32'h0FF0_F0F0);
        chk_res("and", 32'h00F0_F000, 1'b0, 1'b0);
        arith(ARITH_LOGIC, 3'b101, 32'hF0F0_FF00, 32'h0FF0_F0F0);
        chk_res("or", 32'hFFF0_FFF0, 1'b0, 1'b0);
        arith(ARITH_LOGIC, 3'b110, 32'hF0F0_FF00, 32'h0FF0_F0F0);
        chk_res("xor", 32'hFF00_0FF0, 1'b0, 1'b0);
        arith(ARITH_LOGIC, 3'b000, 32'hFFFF_FFFF, 32'h2);
        chk_res("add_c1", 32'h1, 1'b1, 1'b0);
        arith(MEM_READ, 3'b000, 32'hFFFF_FFF0, 32'h20);
        chk_res("memrd", 32'h10, 1'b0, 1'b0);
        arith(3'b010, 3'b000, 32'h3, 32'h4);
        chk_res("bad_sel", 32'h0, 1'b0, 1'b0);

        arith(ARITH_LOGIC, 3'b000, 32'hFFFF_FFFF, 32'h1);
        shift_req(3'b011, 32'h8000_0000, 5'd4);
        chk_res("shra_neg", 32'hF800_0000, 1'b1, 1'b0);
        shift_req(3'b001, 32'h8000_0000, 5'd4);
        chk_res("shrl", 32'h0800_0000, 1'b1, 1'b0);
        shift_req(3'b000, 32'h1, 5'd31);
        chk_res("shll31", 32'h8000_0000, 1'b1, 1'b0);
        shift_req(3'b010, 32'h3, 5'd1);
        chk_res("shla", 32'h6, 1'b1, 1'b0);
        shift_req(3'b011, 32'h7FFF_FFF0, 5'd4);
        chk_res("shra_pos", 32'h07FF_FFFF, 1'b1, 1'b0);
        shift_req(3'b100, 32'hDEAD_BEEF, 5'd3);
        chk_res("sh_pass", 32'hDEAD_BEEF, 1'b1, 1'b0);
        shift_req(3'b000, 32'h7, 5'd0);
        chk_res("sh_zero_n", 32'h7, 1'b1, 1'b0);

        arith(ARITH_LOGIC, 3'b010, 32'h8000_0000, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_out", aluout, 32'h7FFF_FFFF);
            chk("hold_flags", {carry, zero, overflow}, 3'b001);
            chk("hold_vld", out_valid, 1'b0);
        end

        drive(1'b1, 1'b1, ARITH_LOGIC, 3'b000, 32'd2, 32'd3, 5'd4);
        tick();
        idle();
        chk_res("both_en", 32'd5, 1'b0, 1'b0);
        chk("both_busy", busy, 1'b0);
        tick();
        chk("both_after_out", aluout, 32'd5);
        chk("both_after_vld", out_valid, 1'b0);

`ifdef EX_ALU_SERIAL_SHIFT_EN
        drive(1'b0, 1'b1, SHIFT_REG, 3'b000, 32'h1, 32'h0, 5'd5);
        tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            chk("ser_busy", busy, 1'b1);
            chk("ser_vld_lo", out_valid, 1'b0);
            chk("ser_hold", aluout, 32'd5);
            if (i == 1) drive(1'b1, 1'b0, ARITH_LOGIC, 3'b000, 32'd9, 32'd9, 5'd0);
            tick();
            idle();
        end
        chk("ser_done_busy", busy, 1'b0);
        chk("ser_done_vld", out_valid, 1'b0);
        tick();
        chk("ser_out", aluout, 32'd32);
        chk("ser_vld", out_valid, 1'b1);
        tick();
        chk("ser_single_pulse", out_valid, 1'b0);
        chk("ser_arith_ignored", aluout, 32'd32);

        drive(1'b0, 1'b1, SHIFT_REG, 3'b000, 32'h1, 32'h0, 5'd10);
        tick();
        idle();
        tick();
        chk("ser_rst_pre_busy", busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("ser_rst_busy", busy, 1'b0);
        chk("ser_rst_out", aluout, 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("ser_rst_quiet_vld", out_valid, 1'b0);
            chk("ser_rst_quiet_out", aluout, 32'h0);
        end
`endif

        arith(ARITH_LOGIC, 3'b000, 32'hFFFF_FFFF, 32'h1);
        arith(ARITH_LOGIC, 3'b000, 32'h7FFF_FFFF, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_out", aluout, 32'h0);
        chk("mid_rst_flags", {carry, zero, overflow}, 3'b000);
        chk("mid_rst_vld", out_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("post_rst_out", aluout, 32'h0);
        chk("post_rst_vld", out_valid, 1'b0);
        chk("post_rst_flags", {carry, zero, overflow}, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
